// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - keypad synchroniser, press/release debouncer and inactivity timeout
module keypad_entry #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_raw,
    input  logic [3:0] key_code_raw,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       entry_clear,
    output logic       busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    // idle_cnt is zeroed on the edge that ends the digit_valid cycle, so the
    // pulse registered while it holds TIMEOUT_CYCLES-2 lands exactly
    // TIMEOUT_CYCLES cycles after the strobe.
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 2);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PRESS_DB = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;
    localparam logic [1:0] REL_DB   = 2'd3;

    logic          key_m;
    logic          key_s;
    logic [3:0]    code_m;
    logic [3:0]    code_s;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    code_cap;
    logic          accept;
    logic          armed;
    logic [TW-1:0] idle_cnt;

    // Two-stage synchroniser; nothing else looks at the raw inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_m  <= 1'b0;
            key_s  <= 1'b0;
            code_m <= 4'h0;
            code_s <= 4'h0;
        end else begin
            key_m  <= key_raw;
            key_s  <= key_m;
            code_m <= key_code_raw;
            code_s <= code_m;
        end
    end

    // Press is accepted on the last stable sample of the press debounce.
    always_comb begin
        accept = (state == PRESS_DB) && key_s && (code_s == code_cap) && (cnt == CNT_LAST);
    end

    // Debounce FSM; the digit register only moves on an accepted press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            code_cap    <= 4'h0;
            digit       <= 4'h0;
            digit_valid <= 1'b0;
        end else begin
            digit_valid <= accept;
            if (accept) begin
                digit <= code_cap;
            end
            case (state)
                IDLE: begin
                    if (key_s) begin
                        state    <= PRESS_DB;
                        code_cap <= code_s;
                        cnt      <= '0;
                    end
                end
                PRESS_DB: begin
                    if (!key_s || (code_s != code_cap)) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= HELD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!key_s) begin
                        state <= REL_DB;
                        cnt   <= '0;
                    end
                end
                REL_DB: begin
                    if (key_s) begin
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Inactivity timer: armed by a strobe, fires once, and a press accepted
    // on the expiry edge suppresses the pulse so the strobe restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed       <= 1'b0;
            idle_cnt    <= '0;
            entry_clear <= 1'b0;
        end else begin
            entry_clear <= 1'b0;
            if (digit_valid) begin
                armed    <= 1'b1;
                idle_cnt <= '0;
            end else if (armed) begin
                if (idle_cnt == IDLE_LAST) begin
                    idle_cnt <= '0;
                    if (!accept) begin
                        entry_clear <= 1'b1;
                        armed       <= 1'b0;
                    end
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - randomized and directed checks of keypad_entry against a trace model
module tb_keypad_entry;

    localparam int D    = 4;
    localparam int TA   = 1000;
    localparam int TB   = 20;
    localparam int NMAX = 512;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_raw = 1'b0;
    logic [3:0] key_code_raw = 4'h0;
    logic [3:0] dig_a, dig_b;
    logic       dv_a, dv_b, ec_a, ec_b, busy_a, busy_b;

    keypad_entry #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(TA)) dut_a (
        .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .key_code_raw(key_code_raw),
        .digit(dig_a), .digit_valid(dv_a), .entry_clear(ec_a), .busy(busy_a)
    );

    keypad_entry #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(TB)) dut_b (
        .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .key_code_raw(key_code_raw),
        .digit(dig_b), .digit_valid(dv_b), .entry_clear(ec_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int n = 0;

    logic       key_arr [NMAX];
    logic [3:0] code_arr[NMAX];
    logic       o_dv[NMAX], o_busy[NMAX], o_eca[NMAX], o_ecb[NMAX];
    logic [3:0] o_dig[NMAX];
    logic       e_dv[NMAX], e_busy[NMAX], e_eca[NMAX], e_ecb[NMAX];
    logic [3:0] e_dig[NMAX];

    // Synchronised view of the stimulus: what the debouncer sees at edge k.
    function automatic logic sk(input int k);
        return (k >= 2 && k - 2 < n) ? key_arr[k-2] : 1'b0;
    endfunction

    function automatic logic [3:0] sc(input int k);
        return (k >= 2 && k - 2 < n) ? code_arr[k-2] : 4'h0;
    endfunction

    task automatic append(input logic k, input logic [3:0] c, input int len);
        for (int i = 0; i < len; i++) begin
            if (n < NMAX) begin
                key_arr[n]  = k;
                code_arr[n] = c;
                n++;
            end
        end
    endtask

    task automatic mark_busy(input int a, input int b);
        for (int k = a; k <= b; k++) if (k >= 0 && k < NMAX) e_busy[k] = 1'b1;
    endtask

    // Window-scanning model: a press is a run of D+1 synchronised samples that are
    // high with one code; a release is a run of D+1 low samples.
    task automatic build_model();
        int i, t, j, u, dl;
        int acc_e[$];
        logic [3:0] acc_c[$];
        for (int k = 0; k < NMAX; k++) begin
            e_dv[k] = 0; e_dig[k] = 0; e_busy[k] = 0; e_eca[k] = 0; e_ecb[k] = 0;
        end
        i = 0;
        while (i < n) begin
            if (!sk(i)) begin
                i++;
                continue;
            end
            t = i;
            j = 1;
            while (j <= D && sk(t + j) && sc(t + j) == sc(t)) j++;
            if (j <= D) begin
                mark_busy(t, t + j - 1);
                i = t + j + 1;
                continue;
            end
            acc_e.push_back(t + D);
            acc_c.push_back(sc(t));
            u = t + D + 1;
            forever begin
                while (sk(u)) u++;
                j = 1;
                while (j <= D && !sk(u + j)) j++;
                if (j > D) break;
                u = u + j + 1;
            end
            mark_busy(t, u + D - 1);
            i = u + D + 1;
        end
        for (int m = 0; m < acc_e.size(); m++) begin
            for (int k = acc_e[m]; k < NMAX; k++) e_dig[k] = acc_c[m];
            if (acc_e[m] < NMAX) e_dv[acc_e[m]] = 1'b1;
            dl = acc_e[m] + TA;
            if (!(m + 1 < acc_e.size() && acc_e[m+1] <= dl) && dl < NMAX) e_eca[dl] = 1'b1;
            dl = acc_e[m] + TB;
            if (!(m + 1 < acc_e.size() && acc_e[m+1] <= dl) && dl < NMAX) e_ecb[dl] = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        key_raw = 1'b0;
        key_code_raw = 4'h0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_trace();
        do_reset();
        for (int i = 0; i < n; i++) begin
            key_raw = key_arr[i];
            key_code_raw = code_arr[i];
            @(posedge clk);
            #1;
            o_dv[i] = dv_a; o_dig[i] = dig_a; o_busy[i] = busy_a; o_eca[i] = ec_a; o_ecb[i] = ec_b;
        end
        key_raw = 1'b0;
        key_code_raw = 4'h0;
    endtask

    function automatic int first_diff();
        for (int k = 0; k < n; k++)
            if (o_dv[k] !== e_dv[k] || o_dig[k] !== e_dig[k] || o_busy[k] !== e_busy[k] ||
                o_eca[k] !== e_eca[k] || o_ecb[k] !== e_ecb[k]) return k;
        return -1;
    endfunction

    function automatic string trace_str(input int k);
        return $sformatf("cycle %0d got dv/dig/busy/eca/ecb %b/%h/%b/%b/%b required %b/%h/%b/%b/%b",
            k, o_dv[k], o_dig[k], o_busy[k], o_eca[k], o_ecb[k],
            e_dv[k], e_dig[k], e_busy[k], e_eca[k], e_ecb[k]);
    endfunction

    function automatic int count_ones(input int sel);
        int c = 0;
        for (int k = 0; k < n; k++)
            c += (sel == 0) ? int'(o_dv[k]) : (sel == 1) ? int'(o_eca[k]) : int'(o_ecb[k]);
        return c;
    endfunction

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({dv_a, ec_a, busy_a, dig_a, dv_b, ec_b, busy_b, dig_b} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_state: got a=%b%b%b%h b=%b%b%b%h required all zero",
                dv_a, ec_a, busy_a, dig_a, dv_b, ec_b, busy_b, dig_b);
        end
    endtask

    task automatic test_clean_press();
        int fd;
        n = 0;
        append(0, 4'h0, 2); append(1, 4'h3, 30); append(0, 4'h0, 20);
        build_model();
        run_trace();
        n_cmp++;
        if (o_dv[8] !== 1'b1 || o_dig[8] !== 4'h3 || count_ones(0) != 1) begin
            n_fail++;
            $display("FAIL clean_strobe: got dv@8=%b digit=%h strobes=%0d required 1/3/1", o_dv[8], o_dig[8], count_ones(0));
        end
        n_cmp++;
        if (o_busy[3] !== 1'b0 || o_busy[4] !== 1'b1 || o_busy[37] !== 1'b1 || o_busy[38] !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_busy: got busy@3,4,37,38=%b%b%b%b required 0110", o_busy[3], o_busy[4], o_busy[37], o_busy[38]);
        end
        fd = first_diff();
        n_cmp++;
        if (fd != -1) begin
            n_fail++;
            $display("FAIL clean_trace: %s", trace_str(fd));
        end
    endtask

    task automatic test_press_bounce();
        int fd;
        n = 0;
        append(0, 4'h0, 2); append(1, 4'h3, 2); append(0, 4'h0, 1); append(1, 4'h3, 2); append(0, 4'h0, 15);
        build_model();
        run_trace();
        n_cmp++;
        if (count_ones(0) != 0 || o_busy[n-1] !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_reject: got strobes=%0d busy_end=%b required 0/0", count_ones(0), o_busy[n-1]);
        end
        fd = first_diff();
        n_cmp++;
        if (fd != -1) begin
            n_fail++;
            $display("FAIL bounce_trace: %s", trace_str(fd));
        end
        n = 0;
        append(0, 4'h0, 2); append(1, 4'h3, 2); append(1, 4'h5, 10); append(0, 4'h0, 15);
        build_model();
        run_trace();
        n_cmp++;
        if (count_ones(0) != 1 || o_dv[11] !== 1'b1 || o_dig[11] !== 4'h5) begin
            n_fail++;
            $display("FAIL code_change_restart: got strobes=%0d dv@11=%b digit=%h required 1/1/5", count_ones(0), o_dv[11], o_dig[11]);
        end
        fd = first_diff();
        n_cmp++;
        if (fd != -1) begin
            n_fail++;
            $display("FAIL code_change_trace: %s", trace_str(fd));
        end
    endtask

    task automatic test_release_bounce();
        int fd;
        n = 0;
        append(0, 4'h0, 2); append(1, 4'h5, 15); append(0, 4'h0, 2); append(1, 4'h5, 2); append(0, 4'h0, 20);
        build_model();
        run_trace();
        n_cmp++;
        if (count_ones(0) != 1 || o_dig[n-1] !== 4'h5) begin
            n_fail++;
            $display("FAIL release_bounce: got strobes=%0d digit=%h required 1/5", count_ones(0), o_dig[n-1]);
        end
        fd = first_diff();
        n_cmp++;
        if (fd != -1) begin
            n_fail++;
            $display("FAIL release_trace: %s", trace_str(fd));
        end
    endtask

    task automatic test_sequence();
        int fd;
        int want[6] = '{3, 3, 5, 2, 5, 6};
        logic [3:0] got[$];
        n = 0;
        append(0, 4'h0, 3);
        for (int i = 0; i < 6; i++) begin
            append(1, want[i][3:0], $urandom_range(6, 15));
            append(0, 4'h0, $urandom_range(6, 12));
        end
        append(0, 4'h0, 10);
        build_model();
        run_trace();
        for (int k = 0; k < n; k++) if (o_dv[k]) got.push_back(o_dig[k]);
        n_cmp++;
        if (got.size() != 6) begin
            n_fail++;
            $display("FAIL seq_count: got %0d strobes required 6", got.size());
        end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== want[i][3:0]) begin
                n_fail++;
                $display("FAIL seq_digit%0d: got %h required %h", i, got[i], want[i][3:0]);
            end
        end
        n_cmp++;
        if (count_ones(1) != 0) begin
            n_fail++;
            $display("FAIL seq_no_clear: got %0d entry_clear pulses required 0", count_ones(1));
        end
        fd = first_diff();
        n_cmp++;
        if (fd != -1) begin
            n_fail++;
            $display("FAIL seq_trace: %s", trace_str(fd));
        end
    endtask

    task automatic test_timeout();
        int fd;
        n = 0;
        append(0, 4'h0, 2); append(1, 4'h3, 6); append(0, 4'h0, 60);
        build_model();
        run_trace();
        n_cmp++;
        if (o_dv[8] !== 1'b1 || o_ecb[28] !== 1'b1 || count_ones(2) != 1) begin
            n_fail++;
            $display("FAIL timeout_once: got dv@8=%b clear@28=%b clears=%0d required 1/1/1", o_dv[8], o_ecb[28], count_ones(2));
        end
        fd = first_diff();
        n_cmp++;
        if (fd != -1) begin
            n_fail++;
            $display("FAIL timeout_trace: %s", trace_str(fd));
        end
        n = 0;
        append(0, 4'h0, 2); append(1, 4'h3, 6); append(0, 4'h0, 14); append(1, 4'h5, 6); append(0, 4'h0, 50);
        build_model();
        run_trace();
        n_cmp++;
        if (o_dv[28] !== 1'b1 || o_ecb[28] !== 1'b0 || o_ecb[48] !== 1'b1 || count_ones(2) != 1) begin
            n_fail++;
            $display("FAIL timeout_coincide: got dv@28=%b clear@28=%b clear@48=%b clears=%0d required 1/0/1/1",
                o_dv[28], o_ecb[28], o_ecb[48], count_ones(2));
        end
        fd = first_diff();
        n_cmp++;
        if (fd != -1) begin
            n_fail++;
            $display("FAIL coincide_trace: %s", trace_str(fd));
        end
    endtask

    task automatic test_random();
        int fd;
        for (int it = 0; it < 6; it++) begin
            n = 0;
            append(0, 4'h0, 3);
            for (int s = 0; s < 14; s++) begin
                if ($urandom_range(0, 1) == 1)
                    append(1, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h9, $urandom_range(1, 9));
                else
                    append(0, 4'h0, $urandom_range(1, 9));
            end
            append(0, 4'h0, 12);
            build_model();
            run_trace();
            fd = first_diff();
            n_cmp++;
            if (fd != -1) begin
                n_fail++;
                $display("FAIL random_trace%0d: %s", it, trace_str(fd));
            end
        end
    endtask

    task automatic test_reset_mid();
        int e;
        for (int phase = 0; phase < 2; phase++) begin
            do_reset();
            key_raw = 1'b1;
            key_code_raw = 4'h7;
            repeat ((phase == 0) ? 4 : 14) @(posedge clk);
            #1;
            n_cmp++;
            if (busy_a !== 1'b1 || dig_a !== ((phase == 0) ? 4'h0 : 4'h7)) begin
                n_fail++;
                $display("FAIL reset_pre%0d: got busy=%b digit=%h required 1/%h", phase, busy_a, dig_a, (phase == 0) ? 4'h0 : 4'h7);
            end
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            n_cmp++;
            if ({dv_a, ec_a, busy_a, dig_a, dv_b, ec_b, busy_b, dig_b} !== 14'd0) begin
                n_fail++;
                $display("FAIL reset_mid%0d: got a=%b%b%b%h b=%b%b%b%h required all zero",
                    phase, dv_a, ec_a, busy_a, dig_a, dv_b, ec_b, busy_b, dig_b);
            end
            rst_n = 1'b1;
            e = 0;
            for (int k = 1; k <= 40 && e == 0; k++) begin
                @(posedge clk);
                #1;
                if (dv_a) e = k;
            end
            n_cmp++;
            if (e != D + 3 || dig_a !== 4'h7) begin
                n_fail++;
                $display("FAIL reset_held%0d: got strobe at edge %0d digit=%h required edge %0d digit 7", phase, e, dig_a, D + 3);
            end
        end
        key_raw = 1'b0;
        key_code_raw = 4'h0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_sequence();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Front-end stage for the combination lock. Samples a raw mechanical keypad (press line plus 4-bit key code), synchronises and debounces it, and emits exactly one clean single-cycle digit strobe per physical key press. Also produces an inactivity clear pulse, so the downstream lock state machine returns to its initial state when entry stalls. Sits directly upstream of the lock FSM and its state register.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable samples required to accept a press or a release; legal range 2..65535.
- TIMEOUT_CYCLES, 1000: idle cycles after the last accepted digit before entry_clear fires; legal range 2..2^24-1.
- clk  in  1  single clock; all flops are rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- key_raw  in  1  raw key-pressed line; asynchronous and bouncy.
- key_code_raw  in  4  raw code of the pressed key; asynchronous; meaningful only while key_raw is high.
- digit  out  4  code of the last accepted key; held until the next accept.
- digit_valid  out  1  one-cycle strobe; digit is new in this cycle.
- entry_clear  out  1  one-cycle strobe; inactivity timeout.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Synchroniser: key_raw and key_code_raw each pass through 2 flop stages, giving key_s and code_s. No other logic reads the raw inputs.
- FSM states: IDLE, PRESS_DB, HELD, REL_DB. A single debounce counter cnt is sized with $clog2(DEBOUNCE_CYCLES).
  - IDLE: if key_s=1, go to PRESS_DB, set code_cap<=code_s and cnt<=0.
  - PRESS_DB: if key_s=0 or code_s!=code_cap, go to IDLE (bounce rejected, no output). Otherwise, if cnt==DEBOUNCE_CYCLES-1, go to HELD, set digit<=code_cap and digit_valid<=1. Otherwise cnt++.
  - HELD: if key_s=0, go to REL_DB with cnt<=0. A code_s change while held is ignored.
  - REL_DB: if key_s=1, go to HELD (release bounce, no new strobe). Otherwise, if cnt==DEBOUNCE_CYCLES-1, go to IDLE. Otherwise cnt++.
- Exactly one digit_valid per accepted press, however long the key is held.
- Timeout:
  - armed flag is set by digit_valid and cleared by entry_clear.
  - idle counter is cleared when digit_valid=1 and increments every cycle while armed, regardless of FSM state. A key held too long therefore times out.
  - When the idle counter reaches TIMEOUT_CYCLES, entry_clear<=1 for one cycle and armed is cleared.
  - If digit_valid and timeout expiry coincide, digit_valid wins: entry_clear is suppressed and the counter restarts.
- No entry_clear is generated before the first digit after reset.
- busy = (state!=IDLE), combinational from the state register.

## Timing
- Reset (rst_n=0 at a clock edge) sets:
  - state=IDLE, cnt=0, code_cap=0, armed=0, idle counter=0.
  - both synchroniser stages=0.
  - digit=4'h0, digit_valid=0, entry_clear=0, busy=0.
- Reset mid-operation abandons any press in progress. A key still held when rst_n rises is debounced as a fresh press.
- Press latency: key_raw is first sampled high at edge 1 and stays stable with a stable code. Then:
  - key_s=1 after edge 2.
  - PRESS_DB is entered at edge 3.
  - digit_valid is high in the cycle after edge 3+DEBOUNCE_CYCLES.
  - Minimum press-to-strobe latency is DEBOUNCE_CYCLES+3 edges.
- Release: the next press can be accepted no earlier than DEBOUNCE_CYCLES+1 cycles after key_s falls.
- digit_valid and entry_clear are registered, last exactly one cycle, and are never high together.
- entry_clear is high in the cycle exactly TIMEOUT_CYCLES cycles after the digit_valid cycle, provided no further digit_valid occurs.
- digit changes only on the edge that raises digit_valid.

## Test plan
- Clean press, DEBOUNCE_CYCLES=4: key_raw=1 with code 4'h3, held 30 cycles, then released. Required: a single digit_valid in the cycle after edge 7, digit=3, busy high from edge 3 until the release debounce completes.
- Press bounce: key_raw high 2 cycles, low 1 cycle, high 2 cycles, then low (D=4). Required: no digit_valid, FSM back in IDLE. Code change during PRESS_DB (3 to 5): the press is rejected and restarts.
- Release bounce: hold code 4'h5, then release with a 2-cycle re-glitch high (D=4). Required: exactly one digit_valid, digit=5.
- Full sequence: keys 3, 3, 5, 2, 5, 6 pressed with clean gaps. Required: six strobes carrying digit values 3, 3, 5, 2, 5, 6 in order, and no entry_clear when TIMEOUT_CYCLES=1000.
- Timeout, TIMEOUT_CYCLES=20: one press of 4'h3, then idle. Required: entry_clear high exactly 20 cycles after digit_valid, once only. A second press landing on the expiry cycle yields digit_valid with no entry_clear.
- Reset: assert rst_n=0 mid-PRESS_DB and mid-HELD. Required: all outputs 0 on the next cycle. A key held across reset produces one digit_valid DEBOUNCE_CYCLES+3 edges after rst_n rises.
